// File: rtl/post_processing.sv
// post_processing: final stage of the SRT floating-point divider.
// Normalizes the raw 24-bit quotient mantissa by a precomputed shift amount
// and direction, adjusts the biased exponent, applies zero / overflow /
// underflow handling and packs an IEEE-754 single-precision word.
//
// Build option (macro POST_PROC_OUT_REG_EN):
//   defined   : registered output, latency 1, async active-low reset.
//   undefined : purely combinational, latency 0; clk and rst are unused.
//
// Ports:
//   clk              system clock (rising edge)
//   rst              asynchronous reset, active low
//   in_valid         input operands valid this cycle
//   result[23:0]     unnormalized quotient mantissa
//   shift_nums[4:0]  normalization shift amount
//   right_shift      1 = shift right, 0 = shift left
//   resultsign       sign of the quotient
//   current_exponent biased exponent before normalization
//   out_valid        quotient valid
//   quotient[31:0]   packed result {sign, exponent, fraction}
module post_processing (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [23:0] result,
  input  logic [4:0]  shift_nums,
  input  logic        right_shift,
  input  logic        resultsign,
  input  logic [7:0]  current_exponent,
  output logic        out_valid,
  output logic [31:0] quotient
);

  logic [23:0]       mant;
  logic signed [9:0] exp_adj;
  logic [31:0]       packed_word;

  // Mantissa shift and exponent adjustment. The exponent is computed in
  // 10-bit signed arithmetic so both overflow (>= 255) and underflow (<= 0)
  // remain visible before packing.
  always_comb begin
    mant    = '0;
    exp_adj = '0;
    if (right_shift) begin
      mant    = result >> shift_nums;
      exp_adj = $signed({2'b00, current_exponent}) + $signed({5'b00000, shift_nums});
    end else begin
      mant    = result << shift_nums;
      exp_adj = $signed({2'b00, current_exponent}) - $signed({5'b00000, shift_nums});
    end
  end

  // Packing in priority order: zero, infinity, flush-to-zero, normal.
  always_comb begin
    packed_word = '0;
    if (result == '0) begin
      packed_word = {resultsign, 8'h00, 23'h0};
    end else if (exp_adj >= 10'sd255) begin
      packed_word = {resultsign, 8'hFF, 23'h0};
    end else if (exp_adj <= 10'sd0) begin
      packed_word = {resultsign, 8'h00, 23'h0};
    end else begin
      packed_word = {resultsign, exp_adj[7:0], mant[22:0]};
    end
  end

`ifdef POST_PROC_OUT_REG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      quotient  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        quotient <= packed_word;
      end
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};

  assign out_valid = in_valid;
  assign quotient  = packed_word;
`endif

endmodule

// File: tb/tb_post_processing.sv
module tb_post_processing;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [23:0] result;
  logic [4:0]  shift_nums;
  logic        right_shift;
  logic        resultsign;
  logic [7:0]  current_exponent;
  logic        out_valid;
  logic [31:0] quotient;

  int unsigned errors;
  int unsigned checks;

  post_processing dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .result           (result),
    .shift_nums       (shift_nums),
    .right_shift      (right_shift),
    .resultsign       (resultsign),
    .current_exponent (current_exponent),
    .out_valid        (out_valid),
    .quotient         (quotient)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: straight from the packing rules using wide integer arithmetic.
  function automatic logic [31:0] ref_pack(input logic [23:0] r, input logic [4:0] sh,
                                           input logic rs, input logic sgn,
                                           input logic [7:0] ce);
    longint m;
    longint e;
    if (rs) begin
      m = longint'(r) / (longint'(1) << sh);
      e = longint'(ce) + longint'(sh);
    end else begin
      m = (longint'(r) * (longint'(1) << sh)) % (longint'(1) << 24);
      e = longint'(ce) - longint'(sh);
    end
    if (r == 24'd0)    return {sgn, 31'd0};
    else if (e >= 255) return {sgn, 8'hFF, 23'd0};
    else if (e <= 0)   return {sgn, 31'd0};
    else               return {sgn, 8'(e), 23'(m % (longint'(1) << 23))};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs tracked by the scoreboard.
  logic        exp_valid;
  logic [31:0] exp_q;
  logic        cmp_en;

`ifdef POST_PROC_OUT_REG_EN
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_valid <= 1'b0;
      exp_q     <= 32'd0;
    end else begin
      exp_valid <= in_valid;
      if (in_valid)
        exp_q <= ref_pack(result, shift_nums, right_shift, resultsign, current_exponent);
    end
  end
`else
  always_comb begin
    exp_valid = in_valid;
    exp_q     = ref_pack(result, shift_nums, right_shift, resultsign, current_exponent);
  end
`endif

  always @(negedge clk) begin
    if (cmp_en && rst) begin
      check("stream_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check("stream_quotient", quotient, exp_q);
    end
  end

  task automatic drive(input logic v, input logic [23:0] r, input logic [4:0] sh,
                       input logic rs, input logic sgn, input logic [7:0] ce);
    in_valid         = v;
    result           = r;
    shift_nums       = sh;
    right_shift      = rs;
    resultsign       = sgn;
    current_exponent = ce;
  endtask

  // Drive one vector and check the DUT output once it is due.
  task automatic apply_check(input string name, input logic [23:0] r, input logic [4:0] sh,
                             input logic rs, input logic sgn, input logic [7:0] ce,
                             input logic [31:0] lit);
    check({name, "_model"}, ref_pack(r, sh, rs, sgn, ce), lit);
    drive(1'b1, r, sh, rs, sgn, ce);
`ifdef POST_PROC_OUT_REG_EN
    @(posedge clk);
`endif
    #1;
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_dut"}, quotient, lit);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cmp_en = 1'b0;
    rst    = 1'b0;
    drive(1'b0, 24'd0, 5'd0, 1'b0, 1'b0, 8'd0);
    #3;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
`ifdef POST_PROC_OUT_REG_EN
    check("reset_quotient", quotient, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back to back (also exercises streaming order).
    apply_check("left1",      24'h400000, 5'd1,  1'b0, 1'b0, 8'd127, 32'h3F000000);
    apply_check("noshift",    24'h800000, 5'd0,  1'b0, 1'b1, 8'd128, 32'hC0000000);
    apply_check("right1",     24'hC00000, 5'd1,  1'b1, 1'b0, 8'd127, 32'h40600000);
    apply_check("overflow",   24'h800000, 5'd10, 1'b1, 1'b0, 8'd250, 32'h7F800000);
    apply_check("underflow",  24'h800000, 5'd5,  1'b0, 1'b1, 8'd3,   32'h80000000);
    apply_check("zero",       24'h000000, 5'd7,  1'b1, 1'b1, 8'd200, 32'h80000000);
    apply_check("exp255",     24'h800000, 5'd1,  1'b1, 1'b0, 8'd254, 32'h7F800000);
    apply_check("exp254",     24'h800000, 5'd0,  1'b0, 1'b0, 8'd254, 32'h7F000000);
    apply_check("exp0",       24'h800000, 5'd3,  1'b0, 1'b0, 8'd3,   32'h00000000);
    apply_check("exp1",       24'h800000, 5'd2,  1'b0, 1'b0, 8'd3,   32'h00800000);

    // Hold: quotient keeps its value while in_valid is low.
    drive(1'b0, 24'h123456, 5'd4, 1'b1, 1'b1, 8'd77);
`ifdef POST_PROC_OUT_REG_EN
    @(posedge clk);
    #1;
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    check("hold_quotient", quotient, 32'h00800000);
`else
    #1;
    check("comb_invalid", {31'd0, out_valid}, 32'd0);
`endif

    // Randomized stream checked every cycle by the compare process.
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [23:0] r;
      r = 24'($urandom);
      case ($urandom_range(0, 3))
        0: r = 24'd0;
        1: r = r | 24'h800000;
        default: ;
      endcase
      drive(($urandom_range(0, 3) != 0), r, 5'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom_range(0, 8) + 247 * $urandom_range(0, 1)));
      @(posedge clk);
      #1;
    end

`ifdef POST_PROC_OUT_REG_EN
    // Mid-cycle reset discards the pending result immediately.
    cmp_en = 1'b0;
    drive(1'b1, 24'h800000, 5'd0, 1'b0, 1'b0, 8'd128);
    @(posedge clk);
    #1;
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    check("pre_reset_quotient", quotient, 32'h40000000);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_quotient", quotient, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 24'hC00000, 5'd1, 1'b1, 1'b0, 8'd127);
    @(posedge clk);
    #1;
    check("post_reset_quotient", quotient, 32'h40600000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
